// File: rtl/arith_pkg.sv
// Shared arithmetic types and constants for the bit-serial datapaths.
package arith_pkg;

   localparam int unsigned ARITH_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - b_in, with borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic b_in,
   output logic d,
   output logic b_out
);

   always_comb begin
      d     = x ^ y ^ b_in;
      b_out = (~x & y) | (~(x ^ y) & b_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Result appears after WIDTH shift cycles with a one-cycle done pulse.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned WIDTH = ARITH_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   sub_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             bor_q, bor_d;
   logic             borrow_out_q, borrow_out_d;
   logic             bit_d, bit_bor;

   full_subtractor u_fs (
      .x     (a_q[0]),
      .y     (b_q[0]),
      .b_in  (bor_q),
      .d     (bit_d),
      .b_out (bit_bor)
   );

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      diff_d       = diff_q;
      cnt_d        = cnt_q;
      bor_d        = bor_q;
      borrow_out_d = borrow_out_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d          = a;
               b_d          = b;
               diff_d       = '0;
               cnt_d        = '0;
               bor_d        = 1'b0;
               borrow_out_d = 1'b0;
               state_d      = SHIFT;
            end
         end
         SHIFT: begin
            a_d    = a_q >> 1;
            b_d    = b_q >> 1;
            diff_d = {bit_d, diff_q[WIDTH-1:1]};
            bor_d  = bit_bor;
            cnt_d  = cnt_q + CntW'(1);
            // The WIDTH-th shift also publishes the final borrow for the done cycle.
            if (cnt_q == CntW'(WIDTH - 1)) begin
               borrow_out_d = bit_bor;
               state_d      = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         cnt_q        <= '0;
         bor_q        <= 1'b0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_q          <= a_d;
         b_q          <= b_d;
         diff_q       <= diff_d;
         cnt_q        <= cnt_d;
         bor_q        <= bor_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table plus multi-cycle corner sequences.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] diff;
      logic         bor;
   } vec_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;

   int n_vec;
   int n_err;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Drive a request and return just after the accepting edge.
   task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input vec_t v);
      int cyc;
      int nbusy;
      start_op(v.a, v.b);
      cyc   = 0;
      nbusy = busy ? 1 : 0;
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      while (!done && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (busy) nbusy++;
      end
      chk("done_latency", cyc, W);
      chk("busy_cycles_to_done", nbusy, W + 1);
      chk("diff", diff, v.diff);
      chk("borrow_out", borrow_out, v.bor);
      @(posedge clk);
      #1;
      chk("done_single_pulse", done, 0);
      chk("busy_after_done", busy, 0);
      chk("diff_hold", diff, v.diff);
      chk("borrow_hold", borrow_out, v.bor);
   endtask

   initial begin
      vec_t vecs[7];
      vec_t v;
      int   ndone;
      logic [W-1:0] cap_diff[2];
      logic         cap_bor[2];
      int           cap_cyc[2];

      vecs[0] = '{a: 8'd200, b: 8'd45,  diff: 8'd155, bor: 1'b0};
      vecs[1] = '{a: 8'd45,  b: 8'd200, diff: 8'd101, bor: 1'b1};
      vecs[2] = '{a: 8'h5A,  b: 8'h5A,  diff: 8'h00,  bor: 1'b0};
      vecs[3] = '{a: 8'h00,  b: 8'h01,  diff: 8'hFF,  bor: 1'b1};
      vecs[4] = '{a: 8'hFF,  b: 8'h00,  diff: 8'hFF,  bor: 1'b0};
      vecs[5] = '{a: 8'h80,  b: 8'h01,  diff: 8'h7F,  bor: 1'b0};
      vecs[6] = '{a: 8'h01,  b: 8'h80,  diff: 8'h81,  bor: 1'b1};

      n_vec = 0;
      n_err = 0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      rst_n = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_diff", diff, 0);
      chk("rst_borrow", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_op(vecs[i]);

      // Start during SHIFT must be ignored, not queued.
      start_op(8'd10, 8'd3);
      ndone       = 0;
      cap_diff[0] = '0;
      cap_bor[0]  = 1'b1;
      for (int cyc = 1; cyc <= W + 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         if (cyc == 4) begin
            start = 1'b1;
            a     = 8'd99;
            b     = 8'd1;
         end
         if (cyc == 5) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) begin
            ndone++;
            cap_diff[0] = diff;
            cap_bor[0]  = borrow_out;
         end
      end
      chk("ignored_start_done_count", ndone, 1);
      chk("ignored_start_diff", cap_diff[0], 7);
      chk("ignored_start_borrow", cap_bor[0], 0);
      chk("ignored_start_idle", busy, 0);

      // Async reset mid-operation.
      run_op(vecs[1]);
      start_op(8'd200, 8'd45);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_diff", diff, 0);
      chk("abort_borrow", borrow_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int cyc = 0; cyc < W + 4; cyc++) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      v = vecs[0];
      run_op(v);

      // Start held high: back-to-back ops at WIDTH+2 spacing, each with its own operands.
      start_op(8'd7, 8'd2);
      ndone = 0;
      for (int cyc = 1; cyc <= 2 * W + 8; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            a = 8'd3;
            b = 8'd5;
         end
         if (cyc == W + 4) start = 1'b0;
         @(posedge clk);
         #1;
         if (done && ndone < 2) begin
            cap_diff[ndone] = diff;
            cap_bor[ndone]  = borrow_out;
            cap_cyc[ndone]  = cyc;
         end
         if (done) ndone++;
      end
      chk("b2b_done_count", ndone, 2);
      chk("b2b_first_cycle", cap_cyc[0], W);
      chk("b2b_first_diff", cap_diff[0], 5);
      chk("b2b_first_borrow", cap_bor[0], 0);
      chk("b2b_second_cycle", cap_cyc[1], 2 * W + 2);
      chk("b2b_second_diff", cap_diff[1], 254);
      chk("b2b_second_borrow", cap_bor[1], 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
